// File: rtl/superfrog_pkg.sv
// Shared types and widths for the SuperFrog game sequencer.
package superfrog_pkg;

  localparam int SCOREW = 14;
  localparam int LIVESW = 3;
  localparam int TIMERW = 8;

  typedef enum logic [2:0] {
    ATTRACT  = 3'd0,
    READY    = 3'd1,
    PLAY     = 3'd2,
    DYING    = 3'd3,
    GAMEOVER = 3'd4
  } game_state_t;

  // Clamp a one-bit-wider score sum to the display limit.
  function automatic logic [SCOREW-1:0] sat_score(input logic [SCOREW:0] sum,
                                                  input logic [SCOREW:0] limit);
    return (sum > limit) ? limit[SCOREW-1:0] : sum[SCOREW-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame-pulse down-counter: load N, expire pulses on the Nth frame pulse after the load.
module frame_timer
  import superfrog_pkg::*;
(
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              load,
  input  logic [TIMERW-1:0] value,
  input  logic              frame,
  output logic              expire
);

  logic [TIMERW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      cnt <= '0;
    end else if (load) begin
      // A frame pulse in the load cycle is deliberately swallowed here.
      cnt <= value;
    end else if (frame && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Not gated by load: the load itself is decoded from expire by the FSM.
  assign expire = frame && (cnt == TIMERW'(1));

endmodule

// File: rtl/game_ctrl.sv
// SuperFrog game sequencer: FSM, lives/score/hiscore tracking and sprite control decode.
module game_ctrl
  import superfrog_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 90,
  parameter int GO_FRAMES    = 180,
  parameter int SCORE_DIV    = 10,
  parameter int BONUS        = 5,
  parameter int SCORE_MAX    = 9999
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              frame,
  input  logic              start,
  input  logic              hit,
  input  logic              dodge,
  output game_state_t       state,
  output logic              run_en,
  output logic              obj_rst,
  output logic              frog_vis,
  output logic              frog_dead,
  output logic [LIVESW-1:0] lives,
  output logic [SCOREW-1:0] score,
  output logic [SCOREW-1:0] hiscore
);

  localparam logic [LIVESW-1:0] LIVES_INIT = LIVESW'(LIVES);
  localparam logic [TIMERW-1:0] T_READY    = TIMERW'(READY_FRAMES);
  localparam logic [TIMERW-1:0] T_DEATH    = TIMERW'(DEATH_FRAMES);
  localparam logic [TIMERW-1:0] T_GO       = TIMERW'(GO_FRAMES);
  localparam logic [SCOREW:0]   BONUS_W    = (SCOREW+1)'(BONUS);
  localparam logic [SCOREW:0]   MAX_W      = (SCOREW+1)'(SCORE_MAX);
  localparam logic [7:0]        DIV_LAST   = 8'(SCORE_DIV - 1);

  game_state_t       state_nxt;
  logic              tmr_load;
  logic [TIMERW-1:0] tmr_value;
  logic              tmr_expire;
  logic              new_game;
  logic              lose_life;
  logic              end_game;
  logic [7:0]        div_cnt;
  logic [7:0]        frame_cnt;
  logic              score_tick;
  logic [SCOREW:0]   score_sum;
  logic [SCOREW-1:0] score_nxt;

  frame_timer u_timer (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .load      (tmr_load),
    .value     (tmr_value),
    .frame     (frame),
    .expire    (tmr_expire)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) state <= ATTRACT;
    else            state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    new_game  = 1'b0;
    lose_life = 1'b0;
    end_game  = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ATTRACT: if (start) begin
        state_nxt = READY;
        new_game  = 1'b1;
      end
      READY: if (tmr_expire) state_nxt = PLAY;
      PLAY: if (hit) begin
        state_nxt = DYING;
        lose_life = 1'b1;
      end
      DYING: if (tmr_expire) begin
        if (lives == '0) begin
          state_nxt = GAMEOVER;
          end_game  = 1'b1;
        end else begin
          state_nxt = READY;
        end
      end
      GAMEOVER: begin
        // start takes priority over the auto-return to ATTRACT.
        if (start) begin
          state_nxt = READY;
          new_game  = 1'b1;
        end else if (tmr_expire) begin
          state_nxt = ATTRACT;
        end
      end
      default: state_nxt = ATTRACT;
    endcase

    if (state_nxt != state) begin
      case (state_nxt)
        READY:    begin tmr_load = 1'b1; tmr_value = T_READY; end
        DYING:    begin tmr_load = 1'b1; tmr_value = T_DEATH; end
        GAMEOVER: begin tmr_load = 1'b1; tmr_value = T_GO;    end
        default:  ;
      endcase
    end
  end

  always_comb begin
    run_en    = 1'b1;
    frog_vis  = 1'b0;
    frog_dead = 1'b0;
    case (state)
      READY: begin
        run_en   = 1'b0;
        frog_vis = frame_cnt[3];
      end
      PLAY:     frog_vis = 1'b1;
      DYING: begin
        frog_vis  = 1'b1;
        frog_dead = 1'b1;
      end
      GAMEOVER: run_en = 1'b0;
      default:  ;
    endcase
  end

  // Frame tick and dodge bonus are summed first, then saturated once.
  assign score_tick = frame && (div_cnt == DIV_LAST);
  assign score_sum  = {1'b0, score} + (SCOREW+1)'(score_tick)
                    + (dodge ? BONUS_W : '0);
  assign score_nxt  = sat_score(score_sum, MAX_W);

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      lives     <= LIVES_INIT;
      score     <= '0;
      hiscore   <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      obj_rst   <= 1'b0;
    end else begin
      obj_rst <= (state_nxt == READY) && (state != READY);
      if (frame) frame_cnt <= frame_cnt + 1'b1;

      if (new_game) begin
        score   <= '0;
        lives   <= LIVES_INIT;
        div_cnt <= '0;
      end else if (lose_life) begin
        lives   <= (lives != '0) ? lives - 1'b1 : lives;
        div_cnt <= '0;
      end else if (state == PLAY) begin
        score <= score_nxt;
        if (frame) div_cnt <= score_tick ? 8'd0 : div_cnt + 1'b1;
      end

      if (end_game && (score > hiscore)) hiscore <= score;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table plus multi-cycle game sequences.
module tb_game_ctrl;
  import superfrog_pkg::*;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic rst_pix_n = 1'b0;
  logic frame = 1'b0, start = 1'b0, hit = 1'b0, dodge = 1'b0;

  game_state_t       state, state2;
  logic              run_en, obj_rst, frog_vis, frog_dead;
  logic              run_en2, obj_rst2, frog_vis2, frog_dead2;
  logic [LIVESW-1:0] lives, lives2;
  logic [SCOREW-1:0] score, hiscore, score2, hiscore2;

  game_ctrl dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .start(start),
    .hit(hit), .dodge(dodge), .state(state), .run_en(run_en), .obj_rst(obj_rst),
    .frog_vis(frog_vis), .frog_dead(frog_dead), .lives(lives), .score(score),
    .hiscore(hiscore)
  );

  // Same stimulus, fast scoring: exercises saturation.
  game_ctrl #(.SCORE_DIV(1), .BONUS(5000)) dut2 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .start(start),
    .hit(hit), .dodge(dodge), .state(state2), .run_en(run_en2), .obj_rst(obj_rst2),
    .frog_vis(frog_vis2), .frog_dead(frog_dead2), .lives(lives2), .score(score2),
    .hiscore(hiscore2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] fcnt = 8'd0;

  typedef struct packed {
    logic       f, s, h, d;
    logic [2:0] st;
    logic [2:0] lv;
    logic [13:0] sc;
    logic       run, orst, dead;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input int st, input int lv, input int sc);
    check({tag, " state"}, 32'(state), st);
    check({tag, " lives"}, 32'(lives), lv);
    check({tag, " score"}, 32'(score), sc);
  endtask

  task automatic step(input logic f, input logic s, input logic h, input logic d);
    @(negedge clk_pix);
    frame = f; start = s; hit = h; dodge = d;
    @(posedge clk_pix);
    #1;
    if (!rst_pix_n) fcnt = 8'd0;
    else if (f)     fcnt = fcnt + 8'd1;
    frame = 1'b0; start = 1'b0; hit = 1'b0; dodge = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One life: READY -> PLAY, immediate hit, full DYING.
  task automatic lose_life_quick();
    frames(60);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    frames(90);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{f:0, s:0, h:1, d:0, st:ATTRACT, lv:3, sc:0, run:1, orst:0, dead:0};
    vecs[1] = '{f:0, s:0, h:0, d:1, st:ATTRACT, lv:3, sc:0, run:1, orst:0, dead:0};
    vecs[2] = '{f:1, s:0, h:1, d:1, st:ATTRACT, lv:3, sc:0, run:1, orst:0, dead:0};
    vecs[3] = '{f:1, s:1, h:0, d:0, st:READY,   lv:3, sc:0, run:0, orst:1, dead:0};
    vecs[4] = '{f:0, s:0, h:0, d:0, st:READY,   lv:3, sc:0, run:0, orst:0, dead:0};
    vecs[5] = '{f:0, s:1, h:0, d:0, st:READY,   lv:3, sc:0, run:0, orst:0, dead:0};
    vecs[6] = '{f:0, s:0, h:1, d:0, st:READY,   lv:3, sc:0, run:0, orst:0, dead:0};
    vecs[7] = '{f:0, s:0, h:0, d:1, st:READY,   lv:3, sc:0, run:0, orst:0, dead:0};
    vecs[8] = '{f:1, s:1, h:0, d:0, st:READY,   lv:3, sc:0, run:0, orst:0, dead:0};

    // Reset state
    rst_pix_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_pix_n = 1'b1;
    chk3("reset", ATTRACT, 3, 0);
    check("reset hiscore", 32'(hiscore), 0);
    check("reset run_en", 32'(run_en), 1);
    check("reset frog_vis", 32'(frog_vis), 0);
    check("reset frog_dead", 32'(frog_dead), 0);
    check("reset obj_rst", 32'(obj_rst), 0);

    // ATTRACT ignores hit/dodge; start (with an uncounted frame) enters READY.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].f, vecs[i].s, vecs[i].h, vecs[i].d);
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d lives", i), 32'(lives), 32'(vecs[i].lv));
      check($sformatf("vec%0d score", i), 32'(score), 32'(vecs[i].sc));
      check($sformatf("vec%0d run_en", i), 32'(run_en), 32'(vecs[i].run));
      check($sformatf("vec%0d obj_rst", i), 32'(obj_rst), 32'(vecs[i].orst));
      check($sformatf("vec%0d frog_dead", i), 32'(frog_dead), 32'(vecs[i].dead));
    end

    // One READY frame already counted by vec8; 59th still READY, 60th enters PLAY.
    frames(58);
    check("ready59 state", 32'(state), READY);
    check("ready blink", 32'(frog_vis), 32'(fcnt[3]));
    frames(1);
    check("play state", 32'(state), PLAY);
    check("play run_en", 32'(run_en), 1);
    check("play frog_vis", 32'(frog_vis), 1);

    frames(100);
    check("score 100 frames", 32'(score), 10);
    check("dut2 score 100 frames", 32'(score2), 100);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("score dodge", 32'(score), 15);
    check("dut2 score dodge", 32'(score2), 5100);

    // hit wins over frame and dodge
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk3("hit", DYING, 2, 15);
    check("hit frog_dead", 32'(frog_dead), 1);
    check("hit run_en", 32'(run_en), 1);
    check("dut2 hit score", 32'(score2), 5100);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("dying ignores", DYING, 2, 15);

    frames(89);
    check("dying89 state", 32'(state), DYING);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("dying90", READY, 2, 15);
    check("dying90 obj_rst", 32'(obj_rst), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("obj_rst one cycle", 32'(obj_rst), 0);

    // Divider was cleared by hit: 10th frame coinciding with a dodge adds 6.
    frames(60);
    frames(9);
    check("div9 score", 32'(score), 15);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("frame+dodge score", 32'(score), 21);
    check("dut2 saturate", 32'(score2), 9999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("dut2 saturate held", 32'(score2), 9999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    frames(40);
    check("score 40", 32'(score), 40);
    check("dut2 held after frames", 32'(score2), 9999);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    frames(90);
    frames(60);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk3("last life", DYING, 0, 40);
    frames(89);
    check("hiscore before over", 32'(hiscore), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk3("gameover", GAMEOVER, 0, 40);
    check("gameover hiscore", 32'(hiscore), 40);
    check("gameover run_en", 32'(run_en), 0);
    check("gameover frog_vis", 32'(frog_vis), 0);
    check("dut2 hiscore", 32'(hiscore2), 9999);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    frames(179);
    check("go179 state", 32'(state), GAMEOVER);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("attract return", 32'(state), ATTRACT);
    check("attract hiscore", 32'(hiscore), 40);

    // Second game scores nothing; restart from GAMEOVER at its 50th frame.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk3("game2 start", READY, 3, 0);
    check("game2 obj_rst", 32'(obj_rst), 1);
    for (int i = 0; i < 3; i++) lose_life_quick();
    check("game2 over", 32'(state), GAMEOVER);
    check("game2 hiscore kept", 32'(hiscore), 40);
    frames(49);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk3("restart", READY, 3, 0);
    check("restart obj_rst", 32'(obj_rst), 1);

    // start coinciding with GAMEOVER expiry wins.
    for (int i = 0; i < 3; i++) lose_life_quick();
    frames(179);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk3("start wins", READY, 3, 0);

    // Reset mid-DYING (frame also asserted; reset dominates).
    frames(60);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    frames(30);
    check("pre-reset state", 32'(state), DYING);
    rst_pix_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst_pix_n = 1'b1;
    chk3("midreset", ATTRACT, 3, 0);
    check("midreset hiscore", 32'(hiscore), 0);
    check("midreset run_en", 32'(run_en), 1);
    check("midreset frog_vis", 32'(frog_vis), 0);
    check("midreset frog_dead", 32'(frog_dead), 0);
    check("midreset obj_rst", 32'(obj_rst), 0);
    check("midreset dut2 state", 32'(state2), ATTRACT);
    check("midreset dut2 score", 32'(score2), 0);
    check("midreset dut2 hiscore", 32'(hiscore2), 0);
    check("midreset dut2 frog_dead", 32'(frog_dead2), 0);

    // Timer restarts cleanly after reset.
    frames(20);
    check("attract idle", 32'(state), ATTRACT);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frames(59);
    check("post-reset ready59", 32'(state), READY);
    frames(1);
    check("post-reset play", 32'(state), PLAY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
